comm_frame_monitor: RTL and testbench

Parametrised receive-side link supervisor for the serial comm channel. It sits between the frame deserialiser/CRC calculator and the control logic. It validates each received frame against the computed CRC and the frame error bit, and latches the good payload. It declares a CRC fault after a configurable run of consecutive bad frames, and detects line break (serial line stuck) and frame timeout. All conditions are summarised in a 4-state link-health FSM.

---
 rtl/comm_pkg.sv | 19 +
 rtl/comm_stable_det.sv | 47 ++++
 rtl/comm_frame_monitor.sv | 142 ++++++++++++++
 tb/tb_comm_frame_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and helpers for the serial comm channel receive path.
// Link-health encoding and frame geometry used by the monitor and its bench.
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OK       = 2'd1,
    DEGRADED = 2'd2,
    FAULT    = 2'd3
  } link_state_t;

  localparam int ERR_CNT_W = 16;

  // Frame layout: {error bit, received CRC, payload}.
  function automatic int frame_w(input int payload_w, input int crc_w);
    return payload_w + crc_w + 1;
  endfunction

endpackage

// File: rtl/comm_stable_det.sv
// Stuck-line detector: synchronises a raw serial line and flags a break once
// the line has held one level for BRK_TIME sampled cycles.
module comm_stable_det #(
  parameter int BRK_TIME = 6240,
  parameter int CNT_W    = 16
) (
  input  logic clk_20M,
  input  logic reset_n,
  input  logic clr,
  input  logic serial_in,
  output logic line_brk,
  output logic line_brk_nxt
);

  logic             sync1, sync2, prev;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    cnt_nxt = cnt;
    if (clr || (sync2 != prev))
      cnt_nxt = '0;
    else if (cnt != CNT_W'(BRK_TIME))
      cnt_nxt = cnt + CNT_W'(1);
  end

  // The flag follows the counter by one register stage.
  assign line_brk_nxt = !clr && (cnt == CNT_W'(BRK_TIME));

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      cnt      <= '0;
      line_brk <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1    <= serial_in;
      sync2    <= sync1;
      prev     <= sync2;
      cnt      <= cnt_nxt;
      line_brk <= line_brk_nxt;
    end
  end

endmodule

// File: rtl/comm_frame_monitor.sv
// Receive-side link supervisor: frame validation, payload latch, CRC-fault,
// timeout and line-break detection, summarised in a link-health FSM.
module comm_frame_monitor
  import comm_pkg::*;
#(
  parameter int PAYLOAD_W = 48,
  parameter int CRC_W     = 16,
  parameter int BRK_TIME  = 6240,
  parameter int TIMEOUT   = 6240,
  parameter int ERR_LIMIT = 2,
  parameter int CNT_W     = 16
) (
  input  logic                                  clk_20M,
  input  logic                                  reset_n,
  input  logic [frame_w(PAYLOAD_W, CRC_W)-1:0]  frame_in,
  input  logic [CRC_W-1:0]                      crc_cal,
  input  logic                                  frame_valid,
  input  logic                                  serial_in,
  input  logic                                  non_frame,
  input  logic                                  clr,
  output logic [PAYLOAD_W-1:0]                  data_o,
  output logic                                  data_valid,
  output logic                                  crc_err_o,
  output logic                                  timeout_o,
  output logic                                  line_brk_o,
  output logic                                  fault_o,
  output logic [1:0]                            link_state_o,
  output logic [ERR_CNT_W-1:0]                  err_cnt_o
);

  localparam int MSB = PAYLOAD_W + CRC_W;

  logic [CNT_W-1:0]     tmo_cnt, tmo_cnt_nxt;
  logic                 timeout_nxt, line_brk_nxt;
  logic [3:0]           consec, consec_nxt;
  logic                 crc_err_nxt;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;
  logic                 frame_ok, fv_eff, good, bad;
  link_state_t          state, state_nxt;

  comm_stable_det #(
    .BRK_TIME (BRK_TIME),
    .CNT_W    (CNT_W)
  ) u_brk (
    .clk_20M      (clk_20M),
    .reset_n      (reset_n),
    .clr          (clr),
    .serial_in    (serial_in),
    .line_brk     (line_brk_o),
    .line_brk_nxt (line_brk_nxt)
  );

  assign frame_ok = (crc_cal == frame_in[MSB-1 -: CRC_W]) && !frame_in[MSB];
  // A broken line makes the deserialiser output meaningless, so frames are dropped.
  assign fv_eff   = frame_valid && !line_brk_o && !clr;
  assign good     = fv_eff && frame_ok;
  assign bad      = fv_eff && !frame_ok;

  always_comb begin
    tmo_cnt_nxt = tmo_cnt;
    timeout_nxt = 1'b0;
    if (clr || line_brk_o) begin
      tmo_cnt_nxt = '0;
    end else if (non_frame) begin
      if (tmo_cnt != CNT_W'(TIMEOUT))
        tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
      timeout_nxt = (tmo_cnt == CNT_W'(TIMEOUT));
    end else begin
      tmo_cnt_nxt = '0;
    end
  end

  always_comb begin
    consec_nxt  = consec;
    crc_err_nxt = crc_err_o;
    err_cnt_nxt = err_cnt_o;
    if (clr) begin
      consec_nxt  = '0;
      crc_err_nxt = 1'b0;
      err_cnt_nxt = '0;
    end else if (line_brk_o) begin
      consec_nxt  = '0;
      crc_err_nxt = 1'b0;
    end else if (good) begin
      consec_nxt  = '0;
      crc_err_nxt = 1'b0;
    end else if (bad) begin
      if (consec != 4'(ERR_LIMIT))
        consec_nxt = consec + 4'd1;
      if (consec_nxt == 4'(ERR_LIMIT))
        crc_err_nxt = 1'b1;
      if (err_cnt_o != '1)
        err_cnt_nxt = err_cnt_o + ERR_CNT_W'(1);
    end
  end

  // FAULT is sticky: only a clean frame on a healthy line releases it.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (line_brk_nxt || timeout_nxt || crc_err_nxt) begin
      state_nxt = FAULT;
    end else begin
      unique case (state)
        IDLE, OK, DEGRADED: begin
          if (good)     state_nxt = OK;
          else if (bad) state_nxt = DEGRADED;
        end
        FAULT: if (good && !timeout_o) state_nxt = OK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      data_o     <= '0;
      data_valid <= 1'b0;
      crc_err_o  <= 1'b0;
      timeout_o  <= 1'b0;
      tmo_cnt    <= '0;
      consec     <= '0;
      err_cnt_o  <= '0;
      state      <= IDLE;
    end else begin
      if (good)
        data_o <= frame_in[PAYLOAD_W-1:0];
      data_valid <= good;
      crc_err_o  <= crc_err_nxt;
      timeout_o  <= timeout_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      consec     <= consec_nxt;
      err_cnt_o  <= err_cnt_nxt;
      state      <= state_nxt;
    end
  end

  assign link_state_o = state;
  assign fault_o      = crc_err_o | timeout_o | line_brk_o;

endmodule

// File: tb/tb_comm_frame_monitor.sv
// Directed bench for comm_frame_monitor: frame checks, CRC fault, timeout,
// line break, clr and asynchronous reset, with hand-computed expectations.
module tb_comm_frame_monitor;
  import comm_pkg::*;

  localparam int PAYLOAD_W = 48;
  localparam int CRC_W     = 16;
  localparam int BRK_TIME  = 20;
  localparam int TIMEOUT   = 30;
  localparam int ERR_LIMIT = 2;
  localparam int CNT_W     = 16;

  logic                 clk_20M = 1'b0;
  logic                 reset_n;
  logic [64:0]          frame_in;
  logic [CRC_W-1:0]     crc_cal;
  logic                 frame_valid, serial_in, non_frame, clr;
  logic [PAYLOAD_W-1:0] data_o;
  logic                 data_valid, crc_err_o, timeout_o, line_brk_o, fault_o;
  logic [1:0]           link_state_o;
  logic [15:0]          err_cnt_o;

  int total = 0;
  int bad   = 0;
  logic tog_en;
  logic [PAYLOAD_W-1:0] last_good;

  comm_frame_monitor #(
    .PAYLOAD_W (PAYLOAD_W),
    .CRC_W     (CRC_W),
    .BRK_TIME  (BRK_TIME),
    .TIMEOUT   (TIMEOUT),
    .ERR_LIMIT (ERR_LIMIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_20M      (clk_20M),
    .reset_n      (reset_n),
    .frame_in     (frame_in),
    .crc_cal      (crc_cal),
    .frame_valid  (frame_valid),
    .serial_in    (serial_in),
    .non_frame    (non_frame),
    .clr          (clr),
    .data_o       (data_o),
    .data_valid   (data_valid),
    .crc_err_o    (crc_err_o),
    .timeout_o    (timeout_o),
    .line_brk_o   (line_brk_o),
    .fault_o      (fault_o),
    .link_state_o (link_state_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #25 clk_20M = ~clk_20M;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs sampled 1 time unit after the edge; line toggles when enabled.
  task automatic step();
    @(posedge clk_20M);
    #1;
    if (tog_en) serial_in = ~serial_in;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic err, input logic [15:0] crc_f,
                      input logic [15:0] crc_c, input logic [47:0] pl);
    frame_in    = {err, crc_f, pl};
    crc_cal     = crc_c;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; frame_in = '0; crc_cal = '0; frame_valid = 1'b0;
    serial_in = 1'b0; non_frame = 1'b0; clr = 1'b0; tog_en = 1'b1;
    last_good = '0;
    steps(2);
    check("rst_data",  64'(data_o), 64'h0);
    check("rst_dv",    64'(data_valid), 64'h0);
    check("rst_flags", 64'({crc_err_o, timeout_o, line_brk_o, fault_o}), 64'h0);
    check("rst_state", 64'(link_state_o), 64'(IDLE));
    check("rst_errc",  64'(err_cnt_o), 64'h0);
    reset_n = 1'b1;
    steps(2);

    // Good frame: payload latched, pulse, IDLE -> OK.
    send(1'b0, 16'hBEEF, 16'hBEEF, 48'h1234_5678_9ABC);
    last_good = 48'h1234_5678_9ABC;
    check("good_data",  64'(data_o), 64'(last_good));
    check("good_dv",    64'(data_valid), 64'h1);
    check("good_state", 64'(link_state_o), 64'(OK));
    step();
    check("dv_one_cycle", 64'(data_valid), 64'h0);

    // Two CRC mismatches then a good frame.
    send(1'b0, 16'h1111, 16'h2222, 48'hAAAA_AAAA_AAAA);
    check("bad1_state", 64'(link_state_o), 64'(DEGRADED));
    check("bad1_dv",    64'(data_valid), 64'h0);
    check("bad1_data",  64'(data_o), 64'(last_good));
    check("bad1_errc",  64'(err_cnt_o), 64'd1);
    check("bad1_crce",  64'(crc_err_o), 64'h0);
    send(1'b0, 16'h3333, 16'h4444, 48'h5555_5555_5555);
    check("bad2_state", 64'(link_state_o), 64'(FAULT));
    check("bad2_crce",  64'(crc_err_o), 64'h1);
    check("bad2_errc",  64'(err_cnt_o), 64'd2);
    check("bad2_fault", 64'(fault_o), 64'h1);
    check("bad2_data",  64'(data_o), 64'(last_good));
    send(1'b0, 16'h0F0F, 16'h0F0F, 48'h0000_CAFE_F00D);
    last_good = 48'h0000_CAFE_F00D;
    check("rec_state", 64'(link_state_o), 64'(OK));
    check("rec_crce",  64'(crc_err_o), 64'h0);
    check("rec_data",  64'(data_o), 64'(last_good));
    check("rec_errc",  64'(err_cnt_o), 64'd2);

    // CRC matches but error bit set: still a bad frame.
    send(1'b1, 16'h7777, 16'h7777, 48'hDEAD_BEEF_0001);
    check("ebit_errc",  64'(err_cnt_o), 64'd3);
    check("ebit_dv",    64'(data_valid), 64'h0);
    check("ebit_state", 64'(link_state_o), 64'(DEGRADED));
    check("ebit_data",  64'(data_o), 64'(last_good));
    send(1'b0, 16'h1234, 16'h1234, 48'h0102_0304_0506);
    last_good = 48'h0102_0304_0506;
    check("ebit_rec", 64'(link_state_o), 64'(OK));

    // Timeout: rises on the 31st edge with non_frame high.
    non_frame = 1'b1;
    steps(30);
    check("tmo_before", 64'(timeout_o), 64'h0);
    step();
    check("tmo_rise",  64'(timeout_o), 64'h1);
    check("tmo_fault", 64'(fault_o), 64'h1);
    check("tmo_state", 64'(link_state_o), 64'(FAULT));
    send(1'b0, 16'hAB12, 16'hAB12, 48'h1111_2222_3333);
    last_good = 48'h1111_2222_3333;
    check("tmo_frame_dv",    64'(data_valid), 64'h1);
    check("tmo_frame_data",  64'(data_o), 64'(last_good));
    check("tmo_frame_state", 64'(link_state_o), 64'(FAULT));
    non_frame = 1'b0;
    step();
    check("tmo_fall",       64'(timeout_o), 64'h0);
    check("tmo_fall_state", 64'(link_state_o), 64'(FAULT));
    send(1'b0, 16'h5A5A, 16'h5A5A, 48'h4444_5555_6666);
    last_good = 48'h4444_5555_6666;
    check("tmo_rec", 64'(link_state_o), 64'(OK));

    // Line break: last change sampled at edge 1, flag rises at edge 24.
    step();
    tog_en = 1'b0;
    steps(23);
    check("brk_before", 64'(line_brk_o), 64'h0);
    step();
    check("brk_rise",  64'(line_brk_o), 64'h1);
    check("brk_state", 64'(link_state_o), 64'(FAULT));
    check("brk_fault", 64'(fault_o), 64'h1);
    send(1'b0, 16'h0001, 16'h0002, 48'h7777_7777_7777);
    check("brk_ign_errc", 64'(err_cnt_o), 64'd3);
    send(1'b0, 16'h0003, 16'h0003, 48'h8888_8888_8888);
    check("brk_ign_dv",    64'(data_valid), 64'h0);
    check("brk_ign_data",  64'(data_o), 64'(last_good));
    check("brk_ign_state", 64'(link_state_o), 64'(FAULT));
    serial_in = ~serial_in;
    tog_en    = 1'b1;
    steps(3);
    check("brk_hold", 64'(line_brk_o), 64'h1);
    step();
    check("brk_fall", 64'(line_brk_o), 64'h0);
    steps(5);
    check("brk_sticky", 64'(link_state_o), 64'(FAULT));
    send(1'b0, 16'hC0DE, 16'hC0DE, 48'h9999_AAAA_BBBB);
    last_good = 48'h9999_AAAA_BBBB;
    check("brk_rec", 64'(link_state_o), 64'(OK));

    // clr: counters and FSM cleared, payload held.
    send(1'b0, 16'h0010, 16'h0020, 48'h0);
    send(1'b0, 16'h0030, 16'h0040, 48'h0);
    check("pre_clr_errc", 64'(err_cnt_o), 64'd5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_errc",  64'(err_cnt_o), 64'h0);
    check("clr_state", 64'(link_state_o), 64'(IDLE));
    check("clr_crce",  64'(crc_err_o), 64'h0);
    check("clr_data",  64'(data_o), 64'(last_good));

    // Asynchronous reset mid-cycle with flags active.
    send(1'b0, 16'h0050, 16'h0060, 48'h0);
    send(1'b0, 16'h0070, 16'h0080, 48'h0);
    check("pre_rst_crce", 64'(crc_err_o), 64'h1);
    frame_in    = {1'b0, 16'hFACE, 48'hFEED_FEED_FEED};
    crc_cal     = 16'hFACE;
    frame_valid = 1'b1;
    #5;
    reset_n = 1'b0;
    #1;
    check("arst_data",  64'(data_o), 64'h0);
    check("arst_flags", 64'({data_valid, crc_err_o, timeout_o, line_brk_o, fault_o}), 64'h0);
    check("arst_state", 64'(link_state_o), 64'(IDLE));
    check("arst_errc",  64'(err_cnt_o), 64'h0);
    frame_valid = 1'b0;
    steps(2);
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
